run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 122 ++++++++++++
 tb/tb_run_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run/load controller: loads instructions into memory, then paces the CPU in
// run, single-step (pause) and halt modes from two debounced push buttons.
module run_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run_btn,
  input  logic                  i_step_btn,
  input  logic                  i_rx_dv,
  input  logic                  i_tick,
  input  logic                  i_loopf,
  output logic                  o_cpu_on,
  output logic                  o_control_en,
  output logic                  o_instr_we,
  output logic [ADDR_WIDTH-1:0] o_instr_addr,
  output logic [ADDR_WIDTH:0]   o_instr_count,
  output logic [1:0]            o_state,
  output logic                  o_halted,
  output logic                  o_overflow
);

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   run_q;
  logic   step_q;
  logic   run_rel;
  logic   step_rel;
  logic   mem_full;
  logic   has_instr;
  logic   ctrl_nxt;
  logic   enter_load;

  assign run_rel   = run_q & ~i_run_btn;
  assign step_rel  = step_q & ~i_step_btn;
  assign mem_full  = o_instr_count[ADDR_WIDTH];
  assign has_instr = |o_instr_count;
  assign o_state   = state;

  // Next state follows the event priority: run release > loopf > step release > tick.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (run_rel && has_instr)       state_nxt = RUN;
        else if (step_rel && has_instr) state_nxt = PAUSE;
      end
      RUN: begin
        if (run_rel)       state_nxt = LOAD;
        else if (i_loopf)  state_nxt = HALT;
        else if (step_rel) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (run_rel)      state_nxt = RUN;
        else if (i_loopf) state_nxt = HALT;
      end
      HALT: begin
        if (run_rel) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Advance strobes only fire when the state is kept, so no pulse on a leaving edge.
  always_comb begin
    ctrl_nxt = 1'b0;
    if (state == RUN && state_nxt == RUN)
      ctrl_nxt = i_tick;
    else if (state == PAUSE && state_nxt == PAUSE)
      ctrl_nxt = step_rel;
  end

  assign enter_load = (state != LOAD) && (state_nxt == LOAD);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= LOAD;
      run_q         <= 1'b0;
      step_q        <= 1'b0;
      o_cpu_on      <= 1'b0;
      o_control_en  <= 1'b0;
      o_instr_we    <= 1'b0;
      o_instr_addr  <= '0;
      o_instr_count <= '0;
      o_halted      <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      run_q        <= i_run_btn;
      step_q       <= i_step_btn;
      state        <= state_nxt;
      o_cpu_on     <= (state_nxt != LOAD);
      o_halted     <= (state_nxt == HALT);
      o_control_en <= ctrl_nxt;
      o_instr_we   <= 1'b0;

      // A strobe on the edge that leaves LOAD is still captured.
      if (state == LOAD && i_rx_dv) begin
        if (mem_full) begin
          o_overflow <= 1'b1;
        end else begin
          o_instr_we    <= 1'b1;
          o_instr_addr  <= o_instr_count[ADDR_WIDTH-1:0];
          o_instr_count <= o_instr_count + 1'b1;
        end
      end

      if (enter_load) begin
        o_instr_count <= '0;
        o_instr_addr  <= '0;
        o_overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a default-width and a 2-bit-address instance
// share stimulus; write and advance pulses are matched against queued expectations.
module tb_run_ctrl;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_run_btn = 1'b0;
  logic i_step_btn = 1'b0;
  logic i_rx_dv = 1'b0;
  logic i_tick = 1'b0;
  logic i_loopf = 1'b0;

  logic       o_cpu_on, o_control_en, o_instr_we, o_halted, o_overflow;
  logic [7:0] o_instr_addr;
  logic [8:0] o_instr_count;
  logic [1:0] o_state;

  logic       s_cpu_on, s_control_en, s_instr_we, s_halted, s_overflow;
  logic [1:0] s_instr_addr;
  logic [2:0] s_instr_count;
  logic [1:0] s_state;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;
  int m_cnt = 0;
  int m_cnt_s = 0;
  int m_ovf_s = 0;
  int wq_addr[$], wq_cyc[$];
  int ws_addr[$], ws_cyc[$];
  int pq_cyc[$];

  run_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run_btn(i_run_btn), .i_step_btn(i_step_btn),
    .i_rx_dv(i_rx_dv), .i_tick(i_tick), .i_loopf(i_loopf),
    .o_cpu_on(o_cpu_on), .o_control_en(o_control_en), .o_instr_we(o_instr_we),
    .o_instr_addr(o_instr_addr), .o_instr_count(o_instr_count), .o_state(o_state),
    .o_halted(o_halted), .o_overflow(o_overflow)
  );

  run_ctrl #(.ADDR_WIDTH(2)) dut_s (
    .i_clk(i_clk), .i_rst(i_rst), .i_run_btn(i_run_btn), .i_step_btn(i_step_btn),
    .i_rx_dv(i_rx_dv), .i_tick(i_tick), .i_loopf(i_loopf),
    .o_cpu_on(s_cpu_on), .o_control_en(s_control_en), .o_instr_we(s_instr_we),
    .o_instr_addr(s_instr_addr), .o_instr_count(s_instr_count), .o_state(s_state),
    .o_halted(s_halted), .o_overflow(s_overflow)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_instr_we) begin
      if (wq_addr.size() == 0) check("we_unexp", o_instr_we, 0);
      else begin
        check("we_addr", o_instr_addr, wq_addr.pop_front());
        check("we_cyc", cyc_n, wq_cyc.pop_front());
      end
    end
    if (s_instr_we) begin
      if (ws_addr.size() == 0) check("s_we_unexp", s_instr_we, 0);
      else begin
        check("s_we_addr", s_instr_addr, ws_addr.pop_front());
        check("s_we_cyc", cyc_n, ws_cyc.pop_front());
      end
    end
    if (o_control_en) begin
      if (pq_cyc.size() == 0) check("ctrl_unexp", o_control_en, 0);
      else check("ctrl_cyc", cyc_n, pq_cyc.pop_front());
    end
  end

  task automatic clk1();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain(input string tag);
    clk1();
    clk1();
    check({tag, "_wq_left"}, wq_addr.size(), 0);
    check({tag, "_ws_left"}, ws_addr.size(), 0);
    check({tag, "_pq_left"}, pq_cyc.size(), 0);
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    clk1();
    clk1();
    i_rst = 1'b1;
    m_cnt = 0;
    m_cnt_s = 0;
    m_ovf_s = 0;
  endtask

  task automatic rx_one();
    if (m_cnt < 256) begin
      wq_addr.push_back(m_cnt);
      wq_cyc.push_back(cyc_n + 1);
      m_cnt++;
    end
    if (m_cnt_s < 4) begin
      ws_addr.push_back(m_cnt_s);
      ws_cyc.push_back(cyc_n + 1);
      m_cnt_s++;
    end else m_ovf_s = 1;
    i_rx_dv = 1'b1;
    clk1();
    i_rx_dv = 1'b0;
  endtask

  task automatic rel_run();
    i_run_btn = 1'b1;
    clk1();
    i_run_btn = 1'b0;
    clk1();
  endtask

  task automatic rel_step();
    i_step_btn = 1'b1;
    clk1();
    i_step_btn = 1'b0;
    clk1();
  endtask

  task automatic tick_run();
    pq_cyc.push_back(cyc_n + 1);
    i_tick = 1'b1;
    clk1();
    i_tick = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, checked before any clock edge
    #2 i_rst = 1'b0;
    #1;
    check("rst_state", o_state, 0);
    check("rst_cpu_on", o_cpu_on, 0);
    check("rst_ctrl", o_control_en, 0);
    check("rst_we", o_instr_we, 0);
    check("rst_count", o_instr_count, 0);
    check("rst_ovf", o_overflow, 0);
    do_reset();

    // Three loads
    repeat (3) rx_one();
    check("ld3_count", o_instr_count, 3);
    check("ld3_state", o_state, 0);
    drain("ld3");

    // Run with ticks, then loop finish
    do_reset();
    repeat (2) rx_one();
    rel_run();
    check("run_state", o_state, 1);
    check("run_cpu_on", o_cpu_on, 1);
    for (int i = 0; i < 4; i++) begin
      tick_run();
      clk1();
    end
    i_loopf = 1'b1;
    clk1();
    i_loopf = 1'b0;
    check("halt_state", o_state, 3);
    check("halt_flag", o_halted, 1);
    i_tick = 1'b1;
    clk1();
    clk1();
    i_tick = 1'b0;
    rel_step();
    check("halt_step_ign", o_state, 3);
    rel_run();
    check("halt_to_load", o_state, 0);
    check("halt_to_load_cnt", o_instr_count, 0);
    check("halt_to_load_on", o_cpu_on, 0);
    check("halt_to_load_h", o_halted, 0);
    drain("run");

    // Single step in pause with ticks present
    do_reset();
    rx_one();
    rel_step();
    check("pause_state", o_state, 2);
    for (int i = 0; i < 3; i++) begin
      i_step_btn = 1'b1;
      i_tick = 1'b1;
      clk1();
      i_step_btn = 1'b0;
      pq_cyc.push_back(cyc_n + 1);
      clk1();
      i_tick = 1'b0;
      clk1();
    end
    rel_run();
    check("pause_to_run", o_state, 1);
    tick_run();
    rel_step();
    check("run_to_pause", o_state, 2);
    drain("step");

    // Overflow on the 2-bit instance, then clear by going back to LOAD
    do_reset();
    repeat (5) rx_one();
    check("ovf_s_count", s_instr_count, 4);
    check("ovf_s_flag", s_overflow, m_ovf_s);
    check("ovf_big_flag", o_overflow, 0);
    check("ovf_big_count", o_instr_count, 5);
    rel_run();
    check("ovf_run_state", s_state, 1);
    i_rx_dv = 1'b1;
    clk1();
    i_rx_dv = 1'b0;
    check("rx_in_run_ign", o_instr_count, 5);
    rel_run();
    m_cnt = 0;
    m_cnt_s = 0;
    check("clr_s_state", s_state, 0);
    check("clr_s_count", s_instr_count, 0);
    check("clr_s_ovf", s_overflow, 0);
    check("clr_addr", o_instr_addr, 0);
    rx_one();
    i_run_btn = 1'b1;
    clk1();
    i_run_btn = 1'b0;
    rx_one();
    check("rx_on_exit_state", o_state, 1);
    check("rx_on_exit_count", o_instr_count, 2);
    drain("ovf");

    // Run release with nothing loaded; run release beats loopf
    do_reset();
    rel_run();
    check("empty_run_state", o_state, 0);
    check("empty_run_on", o_cpu_on, 0);
    rx_one();
    rel_run();
    check("prio_pre", o_state, 1);
    i_run_btn = 1'b1;
    clk1();
    i_run_btn = 1'b0;
    i_loopf = 1'b1;
    i_tick = 1'b1;
    clk1();
    i_loopf = 1'b0;
    i_tick = 1'b0;
    check("prio_state", o_state, 0);
    check("prio_ctrl", o_control_en, 0);
    drain("prio");

    // Reset asserted while running with ticks
    do_reset();
    rx_one();
    rel_run();
    i_tick = 1'b1;
    clk1();
    check("pre_rst_ctrl", o_control_en, 1);
    #1 i_rst = 1'b0;
    #1;
    check("mid_rst_state", o_state, 0);
    check("mid_rst_ctrl", o_control_en, 0);
    check("mid_rst_on", o_cpu_on, 0);
    check("mid_rst_count", o_instr_count, 0);
    clk1();
    clk1();
    i_rst = 1'b1;
    m_cnt = 0;
    m_cnt_s = 0;
    clk1();
    i_tick = 1'b0;
    clk1();
    check("post_rst_state", o_state, 0);
    check("post_rst_on", o_cpu_on, 0);
    drain("rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
